sinalizador_jogadores: RTL
==========================

SINALIZADOR_JOGADORES -- requirements
Module: sinalizador_jogadores

Interface
REQ-001 Parameter BLINK_DIV, default 25000000: clock cycles per blink half-period (0.5 s at 50 MHz).
REQ-002 Parameter N_FLASH, default 3: number of on/off flashes in one announcement.
REQ-003 Port clock  input  1: single system clock; all state on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port mostra  input  1: level; 1 = player LED panel enabled.
REQ-006 Port confirma  input  1: single-cycle pulse; requests an announcement of the chosen player.
REQ-007 Port jogador_atual  input  3: index of the player whose turn it is; 0-4 valid, 5-7 = none.
REQ-008 Port jogador_escolhido  input  3: index selected on the player buttons; 0-4 valid, 5-7 = none.
REQ-009 Port leds_jogadores  output  5: active-high LED per player, bit i = player i.
REQ-010 Port ocupado  output  1: 1 while an announcement is in progress.
REQ-011 Port fim_anuncio  output  1: single-cycle pulse when an announcement completes.
REQ-012 Port db_estado  output  2: current FSM state code, for the 7-segment debug display.

Function
REQ-013 FSM states: OCIOSO=0, MOSTRA=1, ANUNCIO=2, FIM=3.
REQ-014 OCIOSO: leds_jogadores=0; mostra=1 -> MOSTRA on the next edge.
REQ-015 MOSTRA: LED of a valid jogador_atual steady on; LED of a valid jogador_escolhido ORed in, gated by blink phase fase.
REQ-016 MOSTRA: mostra=0 -> OCIOSO; confirma=1 with valid jogador_escolhido -> ANUNCIO; mostra=0 takes priority over confirma.
REQ-017 confirma with an invalid jogador_escolhido, or asserted in OCIOSO, ANUNCIO or FIM, is ignored with no side effect.
REQ-018 Blink counter counts 0..BLINK_DIV-1 and wraps; the cycle where the count equals BLINK_DIV-1 is a tick; fase toggles on each tick.
REQ-019 In MOSTRA the blink counter free-runs.
REQ-020 Entering ANUNCIO: alvo latches jogador_escolhido, blink counter clears to 0, fase sets to 1, flash counter clears to 0.
REQ-021 ANUNCIO: leds_jogadores = one-hot(alvo) when fase=1, else 0; ocupado=1; later input changes do not alter alvo.
REQ-022 ANUNCIO: each tick increments the flash counter; on the tick that makes it 2*N_FLASH -> FIM.
REQ-023 ANUNCIO therefore lasts exactly 2*N_FLASH*BLINK_DIV cycles.
REQ-024 mostra=0 during ANUNCIO does not abort the announcement.
REQ-025 FIM lasts one cycle: fim_anuncio=1, leds_jogadores=0, ocupado=0.
REQ-026 From FIM: -> MOSTRA if mostra=1, else OCIOSO; the blink counter restarts at 0 with fase=1.
REQ-027 All outputs are registered or decoded from registered state only; there is no combinational path from any input to ocupado or fim_anuncio.

Reset
REQ-028 reset=0 asynchronously forces: state=OCIOSO, blink counter=0, flash counter=0, fase=1, alvo=7.
REQ-029 During and after reset, outputs are: leds_jogadores=0, ocupado=0, fim_anuncio=0, db_estado=0.
REQ-030 Reset asserted mid-ANUNCIO aborts the announcement and produces no fim_anuncio pulse.

Structure
REQ-031 A shared package holds the state encoding constants, JOG_NENHUM=3'd7 and NUM_JOGADORES=5.
REQ-032 One sub-module, gerador_tick, provides the parameterised BLINK_DIV counter with a synchronous clear input and a tick output.
REQ-033 The index-to-one-hot decode lives inline in this module and returns 0 for indices 5-7.

Verification (BLINK_DIV=4, N_FLASH=2)
REQ-034 Reset, then mostra=1, jogador_atual=2, jogador_escolhido=7 -> MOSTRA with leds=5'b00100 steady.
REQ-035 MOSTRA, jogador_atual=0, jogador_escolhido=3 -> leds alternates between 5'b01001 and 5'b00001 every 4 cycles.
REQ-036 MOSTRA, escolhido=4, confirma pulse -> ocupado=1 for 16 cycles; leds = 5'b10000 / 0 in 4-cycle phases; then one-cycle fim_anuncio; then MOSTRA.
REQ-037 During ANUNCIO, change escolhido to 1 and pulse confirma again -> alvo stays 4; still exactly one fim_anuncio after 16 cycles.
REQ-038 MOSTRA, escolhido=6, confirma pulse -> state stays MOSTRA; ocupado stays 0.
REQ-039 reset=0 at cycle 7 of ANUNCIO -> immediately leds=0, ocupado=0, db_estado=0; no fim_anuncio pulse.

Source files
------------

// File: rtl/sinalizador_jogadores_pkg.sv
// Shared definitions for the player LED panel: state encoding, player
// count and the "no player" index.
package sinalizador_jogadores_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        MOSTRA  = 2'd1,
        ANUNCIO = 2'd2,
        FIM     = 2'd3
    } estado_t;

    localparam logic [2:0] JOG_NENHUM    = 3'd7;
    localparam int         NUM_JOGADORES = 5;

    // Indices 0..NUM_JOGADORES-1 name a player; anything above means "none".
    function automatic logic jogador_valido(input logic [2:0] idx);
        return idx < 3'(NUM_JOGADORES);
    endfunction

endpackage

// File: rtl/sinalizador_jogadores_if.sv
// Bundle of the panel control inputs and the LED/status outputs.
// master = whoever drives the panel requests, slave = the panel itself.
interface sinalizador_jogadores_if;

    logic       mostra;
    logic       confirma;
    logic [2:0] jogador_atual;
    logic [2:0] jogador_escolhido;
    logic [4:0] leds_jogadores;
    logic       ocupado;
    logic       fim_anuncio;
    logic [1:0] db_estado;

    modport master (
        output mostra, confirma, jogador_atual, jogador_escolhido,
        input  leds_jogadores, ocupado, fim_anuncio, db_estado
    );

    modport slave (
        input  mostra, confirma, jogador_atual, jogador_escolhido,
        output leds_jogadores, ocupado, fim_anuncio, db_estado
    );

endinterface

// File: rtl/sinalizador_jogadores_gerador_tick.sv
// Blink time base: counts 0..BLINK_DIV-1 and wraps, flagging the last
// count as a tick. A synchronous clear restarts the count at 0.
module gerador_tick #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    output logic tick
);

    localparam int          W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [W-1:0] ULTIMO = W'(BLINK_DIV - 1);

    logic [W-1:0] contagem;

    // Free-running divider with synchronous clear.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values and simulation matches the synthesized netlist.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (limpa || contagem == ULTIMO) begin
            contagem <= '0;
        end else begin
            contagem <= contagem + W'(1);
        end
    end

    assign tick = (contagem == ULTIMO);

endmodule

// File: rtl/sinalizador_jogadores.sv
// Player LED panel: shows whose turn it is, blinks the selected player
// and, on confirmation, flashes the chosen player N_FLASH times.
module sinalizador_jogadores
    import sinalizador_jogadores_pkg::*;
#(
    parameter int BLINK_DIV = 25000000,
    parameter int N_FLASH   = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    sinalizador_jogadores_if.slave  bus
);

    localparam int                 FLASH_W      = (2 * N_FLASH > 1) ? $clog2(2 * N_FLASH) : 1;
    localparam logic [FLASH_W-1:0] FLASH_ULTIMO = FLASH_W'(2 * N_FLASH - 1);

    estado_t              estado, estado_prox;
    logic                 fase;
    logic [2:0]           alvo;
    logic [FLASH_W-1:0]   cnt_flash;
    logic [2:0]           atual_q;
    logic [2:0]           escolhido_q;
    logic                 tick;
    logic                 inicia_anuncio;
    logic                 limpa_blink;

    // Player index to LED mask; indices 5..7 light nothing.
    function automatic logic [NUM_JOGADORES-1:0] um_quente(input logic [2:0] idx);
        case (idx)
            3'd0:    return 5'b00001;
            3'd1:    return 5'b00010;
            3'd2:    return 5'b00100;
            3'd3:    return 5'b01000;
            3'd4:    return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    // The blink phase restarts whenever a display period begins afresh.
    assign limpa_blink = inicia_anuncio || (estado == OCIOSO) || (estado == FIM);

    gerador_tick #(
        .BLINK_DIV (BLINK_DIV)
    ) u_gerador_tick (
        .clock (clock),
        .reset (reset),
        .limpa (limpa_blink),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next-state logic; leaving MOSTRA on mostra=0 wins over a confirmation.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        estado_prox    = estado;
        inicia_anuncio = 1'b0;
        case (estado)
            OCIOSO: begin
                if (bus.mostra) estado_prox = MOSTRA;
            end
            MOSTRA: begin
                if (!bus.mostra) begin
                    estado_prox = OCIOSO;
                end else if (bus.confirma && jogador_valido(bus.jogador_escolhido)) begin
                    estado_prox    = ANUNCIO;
                    inicia_anuncio = 1'b1;
                end
            end
            ANUNCIO: begin
                if (tick && cnt_flash == FLASH_ULTIMO) estado_prox = FIM;
            end
            FIM: begin
                estado_prox = bus.mostra ? MOSTRA : OCIOSO;
            end
        endcase
    end

    // Blink phase, announcement target, flash count and sampled player indices.
    // NOTE: only control/datapath flops are reset here; every one has a
    // defined power-up value because the outputs decode directly from them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fase        <= 1'b1;
            alvo        <= JOG_NENHUM;
            cnt_flash   <= '0;
            atual_q     <= JOG_NENHUM;
            escolhido_q <= JOG_NENHUM;
        end else begin
            atual_q     <= bus.jogador_atual;
            escolhido_q <= bus.jogador_escolhido;
            if (inicia_anuncio) begin
                alvo      <= bus.jogador_escolhido;
                fase      <= 1'b1;
                cnt_flash <= '0;
            end else if (estado == OCIOSO || estado == FIM) begin
                fase      <= 1'b1;
                cnt_flash <= '0;
            end else if (tick) begin
                fase <= ~fase;
                if (estado == ANUNCIO) cnt_flash <= cnt_flash + FLASH_W'(1);
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.leds_jogadores = '0;
        bus.ocupado        = 1'b0;
        bus.fim_anuncio    = 1'b0;
        case (estado)
            OCIOSO: ;
            MOSTRA: begin
                bus.leds_jogadores = um_quente(atual_q) |
                                     (fase ? um_quente(escolhido_q) : 5'b00000);
            end
            ANUNCIO: begin
                bus.leds_jogadores = fase ? um_quente(alvo) : 5'b00000;
                bus.ocupado        = 1'b1;
            end
            FIM: begin
                bus.fim_anuncio = 1'b1;
            end
        endcase
    end

    assign bus.db_estado = estado;

endmodule
